// File: rtl/clk_div_bank.sv
// Multi-channel tick / divided square-wave generator on the system clock.
// Each channel runs a wrap counter with a divisor that only changes at a period boundary.

module clk_div_lane #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(100)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdata,
  output logic             tick,
  output logic             clk_div
);
  logic [DIV_W-1:0] cnt, div_act, div_pend;
  logic [DIV_W-1:0] cnt_nxt, act_nxt;
  logic             tick_nxt, clk_nxt;

  // act_nxt always samples the pre-write div_pend, so a write landing on a
  // wrap or sync edge only affects the following boundary.
  always_comb begin
    cnt_nxt  = cnt;
    act_nxt  = div_act;
    tick_nxt = 1'b0;
    if (!run || sync) begin
      cnt_nxt = '0;
      act_nxt = div_pend;
    end else if (cnt == div_act - 1'b1) begin
      cnt_nxt  = '0;
      act_nxt  = div_pend;
      tick_nxt = 1'b1;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
    clk_nxt = run && (cnt_nxt >= (act_nxt >> 1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      div_act  <= DIV_RST;
      div_pend <= DIV_RST;
      tick     <= 1'b0;
      clk_div  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_act <= act_nxt;
      tick    <= tick_nxt;
      clk_div <= clk_nxt;
      if (wr) div_pend <= wdata;
    end
  end
endmodule

module clk_div_bank #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 16,
  parameter int DIV_INIT    = 100,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  input  logic             sync_req,
  output logic             ready,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_div
);
  localparam int               DIV_RST_I = (DIV_INIT < 2) ? 2 : DIV_INIT;
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_RST_I);
  localparam int               LK_W      = $clog2(LOCK_CYCLES + 1);
  localparam logic [CH_W:0]    NCH_L     = (CH_W + 1)'(NCH);

  logic [LK_W-1:0]  lock_cnt;
  logic             wr_ok;
  logic [DIV_W-1:0] wdata;

  assign wr_ok = cfg_wr && ({1'b0, cfg_ch} < NCH_L);
  assign wdata = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

  // Settle counter freezes once ready is set; only reset re-arms it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_cnt <= '0;
      ready    <= 1'b0;
      cfg_ack  <= 1'b0;
    end else begin
      cfg_ack <= wr_ok;
      if (!ready) begin
        lock_cnt <= lock_cnt + 1'b1;
        ready    <= (lock_cnt == LK_W'(LOCK_CYCLES - 1));
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    clk_div_lane #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_lane (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .run      (ready && ch_en[g]),
      .sync     (sync_req),
      .wr       (wr_ok && (cfg_ch == CH_W'(g))),
      .wdata    (wdata),
      .tick     (tick[g]),
      .clk_div  (clk_div[g])
    );
  end
endmodule
